uart_rx_frame_parser: RTL and testbench

- Downstream consumer of the UART RX FIFO stage.
- Pops received bytes with a single-cycle read request and accepts the registered byte returned on the following cycle.
- Decodes framed packets of the form SYNC, CMD, LEN, payload[LEN], CHK; streams the payload out byte-by-byte and flags completion or error.
- Sits between the UART receive path and the MCU's command/bootloader logic.

---
 rtl/uart_rx_frame_parser.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_frame_parser.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_parser.sv
// Pulls bytes from the UART RX FIFO and decodes SYNC/CMD/LEN/payload/CHK frames,
// streaming payload bytes and flagging good frames, aborts and their cause.
module uart_rx_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'h5A,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync_reset,
  input  logic        fifo_not_empty,
  output logic        fifo_read_req,
  input  logic        enable_out,
  input  logic [7:0]  data_out,
  output logic [7:0]  frame_cmd,
  output logic [7:0]  frame_len,
  output logic        payload_valid,
  output logic [7:0]  payload_data,
  output logic [7:0]  payload_index,
  output logic        frame_done,
  output logic        frame_error,
  output logic [1:0]  error_code,
  output logic [15:0] frame_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;

  localparam logic [7:0] MAX_LEN_B = (MAX_LEN > 255) ? 8'hFF : 8'(MAX_LEN);
  localparam bit         TO_EN     = (TIMEOUT_CYCLES > 0);
  // Counter only ever has to hold TIMEOUT_CYCLES-1.
  localparam int         TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  logic [2:0]    state;
  logic          read_pending;
  logic          still_pending;
  logic          accept;
  logic [7:0]    rx_byte;
  logic [7:0]    chk;
  logic [7:0]    idx;
  logic [TW-1:0] timeout_cnt;
  logic          timeout_hit;

  assign accept        = enable_out & read_pending;
  assign rx_byte       = data_out;
  assign still_pending = read_pending & ~enable_out;
  assign timeout_hit   = TO_EN && (state != ST_IDLE) && !accept && (timeout_cnt == TO_LAST);

  // A new pop is only issued once the previous byte has come back, so reads
  // alternate request/return and never overlap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pending  <= 1'b0;
      fifo_read_req <= 1'b0;
    end else if (sync_reset) begin
      read_pending  <= 1'b0;
      fifo_read_req <= 1'b0;
    end else begin
      read_pending  <= fifo_read_req | still_pending;
      fifo_read_req <= fifo_not_empty & ~fifo_read_req & ~still_pending;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt <= '0;
    end else if (sync_reset) begin
      timeout_cnt <= '0;
    end else if (accept || timeout_hit || !TO_EN || state == ST_IDLE) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      chk           <= 8'h00;
      idx           <= 8'h00;
      frame_cmd     <= 8'h00;
      frame_len     <= 8'h00;
      payload_valid <= 1'b0;
      payload_data  <= 8'h00;
      payload_index <= 8'h00;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      error_code    <= 2'd0;
      frame_count   <= 16'h0000;
    end else if (sync_reset) begin
      state         <= ST_IDLE;
      chk           <= 8'h00;
      idx           <= 8'h00;
      frame_cmd     <= 8'h00;
      frame_len     <= 8'h00;
      payload_valid <= 1'b0;
      payload_data  <= 8'h00;
      payload_index <= 8'h00;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      error_code    <= 2'd0;
      frame_count   <= 16'h0000;
    end else begin
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (rx_byte == SYNC_BYTE) state <= ST_CMD;
          end
          ST_CMD: begin
            frame_cmd <= rx_byte;
            chk       <= rx_byte;
            state     <= ST_LEN;
          end
          ST_LEN: begin
            frame_len <= rx_byte;
            chk       <= chk + rx_byte;
            idx       <= 8'h00;
            if (rx_byte == 8'h00 || rx_byte > MAX_LEN_B) begin
              frame_error <= 1'b1;
              error_code  <= 2'd1;
              state       <= ST_IDLE;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            payload_valid <= 1'b1;
            payload_data  <= rx_byte;
            payload_index <= idx;
            chk           <= chk + rx_byte;
            idx           <= idx + 8'd1;
            if (idx == frame_len - 8'd1) state <= ST_CHK;
          end
          ST_CHK: begin
            if (rx_byte == chk) begin
              frame_done <= 1'b1;
              if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
            end else begin
              frame_error <= 1'b1;
              error_code  <= 2'd2;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timeout_hit) begin
        // Any read still in flight is left pending; its byte lands in IDLE.
        frame_error <= 1'b1;
        error_code  <= 2'd3;
        state       <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: a FIFO model feeds directed byte
// streams while a monitor pops hand-computed expected events on every strobe.
module tb_uart_rx_frame_parser;

  localparam logic [7:0] SYNC    = 8'h5A;
  localparam int         MAXLEN  = 64;
  localparam int         TIMEOUT = 100;

  logic        clk;
  logic        reset_n;
  logic        sync_reset;
  logic        fifo_not_empty;
  logic        fifo_read_req;
  logic        enable_out;
  logic [7:0]  data_out;
  logic [7:0]  frame_cmd;
  logic [7:0]  frame_len;
  logic        payload_valid;
  logic [7:0]  payload_data;
  logic [7:0]  payload_index;
  logic        frame_done;
  logic        frame_error;
  logic [1:0]  error_code;
  logic [15:0] frame_count;

  logic [53:0] all_outs;
  assign all_outs = {fifo_read_req, frame_cmd, frame_len, payload_valid, payload_data,
                     payload_index, frame_done, frame_error, error_code, frame_count};

  uart_rx_frame_parser #(
    .SYNC_BYTE     (SYNC),
    .MAX_LEN       (MAXLEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync_reset    (sync_reset),
    .fifo_not_empty(fifo_not_empty),
    .fifo_read_req (fifo_read_req),
    .enable_out    (enable_out),
    .data_out      (data_out),
    .frame_cmd     (frame_cmd),
    .frame_len     (frame_len),
    .payload_valid (payload_valid),
    .payload_data  (payload_data),
    .payload_index (payload_index),
    .frame_done    (frame_done),
    .frame_error   (frame_error),
    .error_code    (error_code),
    .frame_count   (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  kind;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void exp_payload(input logic [7:0] d, input logic [7:0] i);
    exp_t e;
    e.kind = 8'd0; e.a = d; e.b = i; e.c = 16'h0;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_done(input logic [7:0] cmd, input logic [7:0] len, input logic [15:0] cnt);
    exp_t e;
    e.kind = 8'd1; e.a = cmd; e.b = len; e.c = cnt;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_error(input logic [1:0] code);
    exp_t e;
    e.kind = 8'd2; e.a = {6'd0, code}; e.b = 8'h0; e.c = 16'h0;
    exp_q.push_back(e);
  endfunction

  task automatic applyStimulus();
    foreach (stim[i]) fifo_q.push_back(stim[i]);
    stim.delete();
  endtask

  task automatic match_event(input string name, input logic [7:0] kind, input logic [7:0] a,
                             input logic [7:0] b, input logic [15:0] c);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_%s: got a=%0h b=%0h c=%0h, expected no output", name, a, b, c);
    end else begin
      e = exp_q.pop_front();
      checkOutput(name, {24'd0, kind, a, b, c}, {24'd0, e.kind, e.a, e.b, e.c});
    end
  endtask

  // FIFO model: a request seen during a cycle returns its byte in the next cycle.
  initial begin
    logic [7:0] popped;
    bit         pop_now;
    enable_out     = 1'b0;
    data_out       = 8'h00;
    fifo_not_empty = 1'b0;
    forever begin
      @(negedge clk);
      pop_now = fifo_read_req && (fifo_q.size() != 0);
      popped  = pop_now ? fifo_q.pop_front() : 8'h00;
      @(posedge clk);
      #1;
      enable_out     = pop_now;
      data_out       = popped;
      fifo_not_empty = (fifo_q.size() != 0);
    end
  end

  // Monitor: every output strobe consumes one expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done || frame_error)
        checkOutput("done_error_exclusive", {63'd0, frame_done & frame_error}, 64'd0);
      if (payload_valid) match_event("payload", 8'd0, payload_data, payload_index, 16'h0);
      if (frame_done)    match_event("frame_done", 8'd1, frame_cmd, frame_len, frame_count);
      if (frame_error)   match_event("frame_error", 8'd2, {6'd0, error_code}, 8'h0, 16'h0);
    end
  end

  task automatic wait_drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #2;
      if (fifo_q.size() == 0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({"drain_", name}, {63'd0, ok}, 64'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fifo_read_req) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit found;
    reset_n    = 1'b1;
    sync_reset = 1'b0;
    #1 reset_n = 1'b0;
    #1 checkOutput("reset_outputs", {10'd0, all_outs}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 10+03+AA+BB+CC = 0x244 -> checksum byte 0x44
    stim = '{8'h5A, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h44};
    exp_payload(8'hAA, 8'd0); exp_payload(8'hBB, 8'd1); exp_payload(8'hCC, 8'd2);
    exp_done(8'h10, 8'h03, 16'd1);
    applyStimulus();
    wait_drain("good_frame", 100);
    checkOutput("frame_cmd_hold", {56'd0, frame_cmd}, 64'h10);
    checkOutput("frame_len_hold", {56'd0, frame_len}, 64'h03);

    stim = '{8'h5A, 8'h10, 8'h01, 8'h22, 8'h00};
    exp_payload(8'h22, 8'd0); exp_error(2'd2);
    applyStimulus();
    wait_drain("bad_checksum", 100);
    checkOutput("error_code_chk", {62'd0, error_code}, 64'd2);
    checkOutput("count_after_bad", {48'd0, frame_count}, 64'd1);

    stim = '{8'h00, 8'hFF, 8'h5A, 8'h01, 8'h01, 8'h7E, 8'h80};
    exp_payload(8'h7E, 8'd0); exp_done(8'h01, 8'h01, 16'd2);
    applyStimulus();
    wait_drain("garbage_then_frame", 100);

    stim = '{8'h5A, 8'h02, 8'h41, 8'h5A, 8'h02, 8'h01, 8'h55, 8'h58};
    exp_error(2'd1); exp_payload(8'h55, 8'd0); exp_done(8'h02, 8'h01, 16'd3);
    applyStimulus();
    wait_drain("len_too_big", 100);

    stim = '{8'h5A, 8'h07, 8'h00};
    exp_error(2'd1);
    applyStimulus();
    wait_drain("len_zero", 100);
    checkOutput("error_code_len", {62'd0, error_code}, 64'd1);

    // LEN = MAX_LEN, payload 0..63: 01+40+2016 = 0x821 -> 0x21
    stim = '{8'h5A, 8'h01, 8'h40};
    for (int i = 0; i < 64; i++) begin
      stim.push_back(8'(i));
      exp_payload(8'(i), 8'(i));
    end
    stim.push_back(8'h21);
    exp_done(8'h01, 8'h40, 16'd4);
    applyStimulus();
    wait_drain("len_max", 400);

    // 03+02+5A+5A = 0xB9; SYNC inside payload is plain data
    stim = '{8'h5A, 8'h03, 8'h02, 8'h5A, 8'h5A, 8'hB9};
    exp_payload(8'h5A, 8'd0); exp_payload(8'h5A, 8'd1); exp_done(8'h03, 8'h02, 16'd5);
    applyStimulus();
    wait_drain("sync_in_payload", 100);

    stim = '{8'h5A, 8'h03};
    exp_error(2'd3);
    applyStimulus();
    wait_drain("timeout", 300);
    checkOutput("error_code_timeout", {62'd0, error_code}, 64'd3);
    checkOutput("frame_cmd_timeout", {56'd0, frame_cmd}, 64'h03);
    checkOutput("frame_len_timeout", {56'd0, frame_len}, 64'h02);

    stim = '{8'h5A, 8'h04, 8'h01, 8'h10, 8'h15};
    exp_payload(8'h10, 8'd0); exp_done(8'h04, 8'h01, 16'd6);
    applyStimulus();
    wait_drain("after_timeout", 100);
    checkOutput("error_code_held", {62'd0, error_code}, 64'd3);

    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus();
    wait_req(found);
    checkOutput("pacing_first_req", {63'd0, found}, 64'd1);
    if (found) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        checkOutput($sformatf("pacing_req_%0d", k), {63'd0, fifo_read_req}, (k % 2 == 1) ? 64'd0 : 64'd1);
      end
    end
    wait_drain("pacing", 100);

    stim = '{8'h5A, 8'h20, 8'h04, 8'h11, 8'h22};
    exp_payload(8'h11, 8'd0); exp_payload(8'h22, 8'd1);
    applyStimulus();
    wait_drain("before_sync_reset", 100);
    // The first 5A below is in flight across sync_reset and must be dropped.
    stim = '{8'h5A, 8'h5A, 8'h09, 8'h01, 8'h01, 8'h0B};
    applyStimulus();
    wait_req(found);
    checkOutput("sync_reset_req_seen", {63'd0, found}, 64'd1);
    sync_reset = 1'b1;
    @(posedge clk);
    #1 sync_reset = 1'b0;
    checkOutput("sync_reset_outputs", {10'd0, all_outs}, 64'd0);
    exp_payload(8'h01, 8'd0); exp_done(8'h09, 8'h01, 16'd1);
    wait_drain("after_sync_reset", 100);

    stim = '{8'h5A, 8'h30, 8'h02, 8'h12};
    exp_payload(8'h12, 8'd0);
    applyStimulus();
    wait_drain("before_async_reset", 100);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 checkOutput("async_reset_outputs", {10'd0, all_outs}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    stim = '{8'h5A, 8'h0A, 8'h01, 8'h03, 8'h0E};
    exp_payload(8'h03, 8'd0); exp_done(8'h0A, 8'h01, 16'd1);
    applyStimulus();
    wait_drain("after_async_reset", 100);
    checkOutput("final_count", {48'd0, frame_count}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
